// File: rtl/bram_lsu_pkg.sv
// Shared types and constants for the BRAM load/store sequencer.
package bram_lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_RESP = 2'd3
  } lsu_state_t;

  localparam logic SIZE_BYTE = 1'b0;
  localparam logic SIZE_WORD = 1'b1;

endpackage

// File: rtl/bram_lsu_ext.sv
// Byte-load extension: widens one byte to a CPU word, sign- or zero-filled.
module lsu_ext #(
  parameter int BYTE = 8,
  parameter int W    = 16
) (
  input  logic [BYTE-1:0] b,
  input  logic            sign_ext,
  output logic [W-1:0]    y
);

  generate
    if (W > BYTE) begin : g_wide
      assign y = {{(W-BYTE){sign_ext & b[BYTE-1]}}, b};
    end else begin : g_narrow
      assign y = b;
    end
  endgenerate

endmodule

// File: rtl/bram_lsu.sv
// Load/store sequencer: splits CPU word/byte accesses into byte accesses on one
// BRAM port and assembles read bytes little-endian across the registered read.
module bram_lsu
  import bram_lsu_pkg::*;
#(
  parameter int ADDR  = 16,
  parameter int BYTE  = 8,
  parameter int LANES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic                  req_size,
  input  logic                  req_signed,
  input  logic [ADDR-1:0]       req_addr,
  input  logic [BYTE*LANES-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [BYTE*LANES-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  mem_wr,
  output logic [ADDR-1:0]       mem_addr,
  output logic [BYTE-1:0]       mem_din,
  input  logic [BYTE-1:0]       mem_dout
);

  localparam int W  = BYTE * LANES;
  localparam int IW = $clog2(LANES + 1);
  localparam logic [ADDR-1:0] AMASK = ADDR'((1 << $clog2(LANES)) - 1);

  lsu_state_t      state, state_d;
  logic [IW-1:0]   idx, idx_d;
  logic [IW-1:0]   n_q;
  logic [ADDR-1:0] base_q;
  logic [W-1:0]    wdata_q;
  logic [W-1:0]    data_q;
  logic            size_q;
  logic            signed_q;
  logic            err_q;
  logic            accept;
  logic            misaligned;
  logic [W-1:0]    ext_word;

  assign accept     = (state == S_IDLE) && req_valid;
  assign misaligned = (req_size == SIZE_WORD) && ((req_addr & AMASK) != '0);

  always_comb begin
    state_d = state;
    idx_d   = idx;
    case (state)
      S_IDLE: begin
        idx_d = '0;
        if (accept) begin
          if (misaligned)  state_d = S_RESP;
          else if (req_wr) state_d = S_WR;
          else             state_d = S_RD;
        end
      end
      S_WR: begin
        if (idx == n_q - IW'(1)) begin
          state_d = S_RESP;
          idx_d   = '0;
        end else begin
          idx_d = idx + IW'(1);
        end
      end
      S_RD: begin
        if (idx == n_q) begin
          state_d = S_RESP;
          idx_d   = '0;
        end else begin
          idx_d = idx + IW'(1);
        end
      end
      S_RESP: begin
        // An error response waits one cycle in RESP (idx used as the delay flag)
        // so that it lands one cycle after the accept edge, like a real access would.
        if (err_q && (idx == '0)) begin
          idx_d = IW'(1);
        end else begin
          state_d = S_IDLE;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      idx      <= '0;
      n_q      <= '0;
      base_q   <= '0;
      wdata_q  <= '0;
      data_q   <= '0;
      size_q   <= 1'b0;
      signed_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state <= state_d;
      idx   <= idx_d;
      if (accept) begin
        base_q   <= req_addr;
        wdata_q  <= req_wdata;
        size_q   <= req_size;
        signed_q <= req_signed;
        err_q    <= misaligned;
        n_q      <= (req_size == SIZE_WORD) ? IW'(LANES) : IW'(1);
        data_q   <= '0;
      end
      // Read data trails the address by one cycle, so it belongs to slot idx-1.
      if (state == S_RD) begin
        for (int unsigned k = 0; k < LANES; k++) begin
          if (idx == IW'(k + 1)) data_q[k*BYTE +: BYTE] <= mem_dout;
        end
      end
    end
  end

  lsu_ext #(.BYTE(BYTE), .W(W)) u_ext (
    .b        (data_q[BYTE-1:0]),
    .sign_ext (signed_q),
    .y        (ext_word)
  );

  assign req_ready = (state == S_IDLE);
  assign mem_wr    = (state == S_WR);
  assign mem_addr  = ((state == S_RD) || (state == S_WR)) ? base_q + ADDR'(idx) : '0;

  always_comb begin
    mem_din = '0;
    if (state == S_WR) begin
      for (int unsigned k = 0; k < LANES; k++) begin
        if (idx == IW'(k)) mem_din = wdata_q[k*BYTE +: BYTE];
      end
    end
  end

  assign resp_valid = (state == S_RESP) && !(err_q && (idx == '0));
  assign resp_err   = resp_valid && err_q;
  assign resp_rdata = (resp_valid && !err_q) ? ((size_q == SIZE_WORD) ? data_q : ext_word) : '0;

endmodule

// File: tb/tb_bram_lsu.sv
// Self-checking bench for bram_lsu with a behavioural byte-wide BRAM and a
// request-level reference model (memory image, latency and result rules).
module tb_bram_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_wr, req_size, req_signed;
  logic [15:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [15:0] resp_rdata;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [7:0]  mem_din, mem_dout;

  bit [7:0] bram [65536];
  bit [7:0] ref_mem [65536];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bram_lsu #(.ADDR(16), .BYTE(8), .LANES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wr     (req_wr),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_wr     (mem_wr),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_dout   (mem_dout)
  );

  // Port-B style BRAM: registered read, read-before-write.
  always @(posedge clk) begin
    if (mem_wr) bram[mem_addr] <= mem_din;
    mem_dout <= bram[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input bit wr, input bit sz, input bit sg,
                        input logic [15:0] a, input logic [15:0] wd);
    bit          err;
    int          n, exp_lat, lat, wrs;
    logic [15:0] exp_rd;
    logic [7:0]  b;
    err     = sz && a[0];
    n       = sz ? 2 : 1;
    exp_lat = err ? 1 : (wr ? n : n + 1);
    exp_rd  = 16'h0000;
    if (!err && !wr) begin
      if (sz) exp_rd = {ref_mem[16'(a + 16'd1)], ref_mem[a]};
      else begin
        b      = ref_mem[a];
        exp_rd = sg ? {{8{b[7]}}, b} : {8'h00, b};
      end
    end
    if (!err && wr) begin
      ref_mem[a] = wd[7:0];
      if (sz) ref_mem[16'(a + 16'd1)] = wd[15:8];
    end

    @(negedge clk);
    check("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_wr = wr; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    // Fields are garbage from here on; the DUT must hold what it captured.
    req_valid = 1'b0; req_wr = $urandom_range(0, 1); req_size = $urandom_range(0, 1);
    req_signed = $urandom_range(0, 1); req_addr = 16'($urandom); req_wdata = 16'($urandom);
    lat = 0; wrs = 0;
    while (!resp_valid && lat < 20) begin
      if (mem_wr) wrs++;
      @(posedge clk); #1;
      lat++;
    end
    check("resp_latency", lat, exp_lat);
    check("resp_rdata", resp_rdata, exp_rd);
    check("resp_err", resp_err, err);
    check("mem_wr_cycles", wrs, (wr && !err) ? n : 0);
    @(posedge clk); #1;
    check("resp_pulse_1cyc", resp_valid, 0);
    if (wr && !err) begin
      check("mem_byte0", bram[a], ref_mem[a]);
      if (sz) check("mem_byte1", bram[16'(a + 16'd1)], ref_mem[16'(a + 16'd1)]);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b1; req_wr = 1'b1; req_size = 1'b1; req_signed = 1'b0;
    req_addr = 16'h0010; req_wdata = 16'hBEEF;

    // Reset held with a pending store
    repeat (3) begin
      @(posedge clk); #1;
      check("rst_mem_wr", mem_wr, 0);
      check("rst_resp_valid", resp_valid, 0);
    end
    @(negedge clk);
    rst_n = 1'b1; req_valid = 1'b0;
    @(posedge clk); #1;
    check("post_rst_ready", req_ready, 1);
    check("post_rst_mem_addr", mem_addr, 0);
    check("post_rst_mem_din", mem_din, 0);
    check("post_rst_rdata", resp_rdata, 0);
    check("post_rst_err", resp_err, 0);

    // Directed sequence
    do_req(1, 1, 0, 16'h0010, 16'hBEEF);
    do_req(0, 1, 0, 16'h0010, 16'h0000);
    do_req(0, 0, 1, 16'h0011, 16'h0000);
    do_req(0, 0, 0, 16'h0011, 16'h0000);
    do_req(0, 1, 0, 16'h0011, 16'h0000);
    do_req(1, 1, 0, 16'h0013, 16'hAAAA);
    do_req(1, 0, 0, 16'h0012, 16'h5A7F);
    do_req(0, 0, 1, 16'h0012, 16'h0000);
    do_req(1, 1, 0, 16'hFFFE, 16'hC381);
    do_req(0, 1, 0, 16'hFFFE, 16'h0000);
    do_req(0, 0, 1, 16'hFFFF, 16'h0000);

    // Reset in the middle of a word store
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b1; req_size = 1'b1; req_signed = 1'b0;
    req_addr = 16'h0020; req_wdata = 16'h1234;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("abort_first_wr", mem_wr, 1);
    check("abort_first_addr", mem_addr, 16'h0020);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort_mem_wr", mem_wr, 0);
    check("abort_resp", resp_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("abort_ready", req_ready, 1);
    repeat (3) begin
      check("abort_no_resp", resp_valid, 0);
      @(posedge clk); #1;
    end
    ref_mem[16'h0020] = 8'h34;
    check("abort_mem20", bram[16'h0020], 8'h34);
    check("abort_mem21", bram[16'h0021], ref_mem[16'h0021]);

    // Random traffic in a small window plus the top-of-memory boundary
    for (int i = 0; i < 80; i++) begin
      logic [15:0] a;
      if ($urandom_range(0, 7) == 0) a = 16'hFFFE + 16'($urandom_range(0, 1));
      else a = 16'h0100 + 16'($urandom_range(0, 15));
      do_req(($urandom_range(0, 2) == 0), $urandom_range(0, 1) == 1,
             $urandom_range(0, 1) == 1, a, 16'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
